// File: rtl/serial_tx_scheduler_if.sv
// serial_tx_scheduler_if: requester-side and transmitter-side signals of serial_tx_scheduler.
interface serial_tx_scheduler_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req, grant;
  logic [8*NUM_REQ-1:0] data_in;
  logic [7:0] tx_data;
  logic tx_load, tx_enable, tx_done, busy, tx_error;
  logic [2:0] active_id;
  logic [15:0] chars_sent;
  modport master (
    output req, data_in, tx_done,
    input grant, tx_data, tx_load, tx_enable, busy, active_id, chars_sent, tx_error
  );
  modport slave (
    input req, data_in, tx_done,
    output grant, tx_data, tx_load, tx_enable, busy, active_id, chars_sent, tx_error
  );
endinterface

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin sharing of one serial transmitter among NUM_REQ byte requesters.
// Optional TX_TIMEOUT_EN: abort SEND after TIMEOUT_CYCLES without tx_done and raise sticky tx_error.
module serial_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clock,
  input logic rst,
  serial_tx_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GRANT, LOAD, SEND, GAP} state_t;
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t state;
  logic [2:0] rr_ptr, pick, pick_next;
  logic [NUM_REQ-1:0] pick_oh;
  logic [7:0] pick_byte;
  logic [15:0] gap_cnt;
  logic timed_out;
  int best;
  // winner is the pending requester at the smallest upward distance from rr_ptr
  always_comb begin
    best = NUM_REQ;
    pick = rr_ptr;
    pick_oh = '0;
    pick_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.req[k] && (k - int'(rr_ptr) + NUM_REQ) % NUM_REQ < best) begin
        best = (k - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
        pick = 3'(k);
        pick_oh = NUM_REQ'(1) << k;
        pick_byte = bus.data_in[8*k +: 8];
      end
    end
  end
  assign pick_next = (pick == 3'(NUM_REQ - 1)) ? 3'd0 : pick + 3'd1;
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      gap_cnt <= '0;
      bus.grant <= '0;
      bus.tx_data <= '0;
      bus.tx_load <= 1'b0;
      bus.tx_enable <= 1'b0;
      bus.busy <= 1'b0;
      bus.active_id <= '0;
      bus.chars_sent <= '0;
    end else begin
      bus.grant <= '0;
      bus.tx_load <= 1'b0;
      case (state)
        IDLE: if (|bus.req) begin
          state <= GRANT;
          bus.grant <= pick_oh;
          bus.tx_data <= pick_byte;
          bus.active_id <= pick;
          bus.busy <= 1'b1;
          rr_ptr <= pick_next;
        end
        GRANT: begin
          state <= LOAD;
          bus.tx_load <= 1'b1;
        end
        LOAD: begin
          state <= SEND;
          bus.tx_enable <= 1'b1;
        end
        SEND: if (bus.tx_done || timed_out) begin
          bus.tx_enable <= 1'b0;
          bus.chars_sent <= bus.chars_sent + {15'd0, bus.tx_done};
          gap_cnt <= GAP_LOAD;
          state <= (GAP_CYCLES == 0) ? IDLE : GAP;
          bus.busy <= (GAP_CYCLES != 0);
        end
        GAP: if (gap_cnt == '0) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tout_cnt;
  // a tx_done on the last allowed cycle wins over the timeout
  assign timed_out = (state == SEND) && (tout_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      tout_cnt <= '0;
      bus.tx_error <= 1'b0;
    end else begin
      tout_cnt <= (state == SEND) ? tout_cnt + 1'b1 : '0;
      if (timed_out && !bus.tx_done) bus.tx_error <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign bus.tx_error = 1'b0;
`endif
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: randomized transaction-level check of serial_tx_scheduler against a round-robin reference model.
`timescale 1ns/1ps
module tb_serial_tx_scheduler;
  localparam int N = 4, GAP = 16, TMO = 32;
`ifdef TX_TIMEOUT_EN
  localparam int DMAX = TMO - 1;
`else
  localparam int DMAX = 40;
`endif
  logic clock = 1'b0, rst = 1'b0;
  int checks = 0, errors = 0;
  int m_ptr = 0, m_sent = 0, m_err = 0;
  logic [7:0] bytes [N];
  serial_tx_scheduler_if #(.NUM_REQ(N)) bus ();
  serial_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .rst(rst), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int rr_model(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  task automatic set_data();
    for (int k = 0; k < N; k++) bus.data_in[8*k +: 8] = bytes[k];
  endtask
  task automatic do_reset();
    bus.req = '0;
    bus.tx_done = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_load", bus.tx_load, 0);
    chk("rst_tx_enable", bus.tx_enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_active_id", bus.active_id, 0);
    chk("rst_chars_sent", bus.chars_sent, 0);
    chk("rst_tx_error", bus.tx_error, 0);
    m_ptr = 0;
    m_sent = 0;
    m_err = 0;
    @(negedge clock);
    rst = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      bus.tx_done = 1'($urandom_range(1));
      @(negedge clock);
    end
    bus.tx_done = 1'b0;
    chk("idle_busy", bus.busy, 0);
    chk("idle_grant", bus.grant, 0);
    chk("idle_sent", bus.chars_sent, m_sent % 65536);
  endtask
  task automatic gap_wait(input bit spurious);
    int n = 0;
    while (bus.busy && n < 200) begin
      bus.tx_done = spurious & 1'($urandom_range(1));
      @(negedge clock);
      n++;
    end
    bus.tx_done = 1'b0;
    chk("gap_len", n, GAP);
    chk("gap_sent", bus.chars_sent, m_sent % 65536);
    chk("gap_enable", bus.tx_enable, 0);
  endtask
  task automatic launch(input logic [N-1:0] add, output int w);
    logic [N-1:0] oh;
    bus.req = bus.req | add;
    set_data();
    w = rr_model(bus.req, m_ptr);
    oh = '0;
    oh[w] = 1'b1;
    @(negedge clock);
    chk("grant", bus.grant, oh);
    chk("tx_data", bus.tx_data, bytes[w]);
    chk("active_id", bus.active_id, w);
    chk("busy", bus.busy, 1);
    m_ptr = (w + 1) % N;
    bus.req[w] = 1'b0;
    @(negedge clock);
    chk("tx_load", bus.tx_load, 1);
    chk("grant_pulse", bus.grant, 0);
    chk("enable_early", bus.tx_enable, 0);
    @(negedge clock);
    chk("tx_enable", bus.tx_enable, 1);
    chk("load_pulse", bus.tx_load, 0);
  endtask
  task automatic xact(input logic [N-1:0] add, input int dly, input bit spurious);
    int w;
    bit held = 1'b1;
    launch(add, w);
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      held &= bus.tx_enable & (bus.tx_data == bytes[w]);
    end
    chk("send_hold", held, 1);
    bus.tx_done = 1'b1;
    @(negedge clock);
    bus.tx_done = 1'b0;
    m_sent++;
    chk("enable_off", bus.tx_enable, 0);
    chk("chars_sent", bus.chars_sent, m_sent % 65536);
    chk("tx_error", bus.tx_error, m_err);
    gap_wait(spurious);
  endtask
`ifdef TX_TIMEOUT_EN
  task automatic xact_timeout(input logic [N-1:0] add);
    int w;
    int n = 0;
    launch(add, w);
    while (bus.tx_enable && n < 200) begin
      @(negedge clock);
      n++;
    end
    m_err = 1;
    chk("tmo_len", n, TMO);
    chk("tmo_error", bus.tx_error, 1);
    chk("tmo_sent", bus.chars_sent, m_sent % 65536);
    gap_wait(1'b0);
  endtask
`endif
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    logic [N-1:0] add;
    for (int k = 0; k < N; k++) bytes[k] = 8'h00;
    bus.req = '0;
    bus.tx_done = 1'b0;
    set_data();
    @(negedge clock);
    do_reset();
    bytes[1] = 8'h41;
    xact(4'b0010, 5, 1'b0);
    idle(6);
    xact(4'b1000, $urandom_range(0, DMAX), 1'b1);
    xact(4'b1001, $urandom_range(0, DMAX), 1'b1);
    xact(4'b0000, $urandom_range(0, DMAX), 1'b0);
    launch(4'b0100, w);
    repeat (3) @(negedge clock);
    chk("pre_reset_enable", bus.tx_enable, 1);
    do_reset();
    xact(4'b1001, 3, 1'b0);
    xact(4'b0000, 3, 1'b0);
    do_reset();
    for (int k = 0; k < N; k++) bytes[k] = 8'h10 + 8'(k);
    repeat (5) xact(4'b1111, 8, 1'b1);
    bus.req = '0;
`ifdef TX_TIMEOUT_EN
    xact_timeout(4'b0100);
    xact(4'b0100, $urandom_range(0, DMAX), 1'b0);
    xact(4'b0001, DMAX, 1'b0);
`endif
    for (int t = 0; t < 30; t++) begin
      if (bus.req == '0) idle($urandom_range(0, 3));
      add = N'($urandom_range(0, 15));
      if ((bus.req | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
      for (int k = 0; k < N; k++) if (add[k] && !bus.req[k]) bytes[k] = 8'($urandom);
      xact(add, $urandom_range(0, DMAX), 1'($urandom_range(1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
